instruction_stream_sequencer: RTL and testbench

- Sits directly upstream of the cpu block and drives its 16-bit current_instruction bus, one instruction per clock_in cycle.
- Buffers host-supplied instructions in a small FIFO (valid/ready) and issues them in order.
- Inserts NOPs wherever the cpu needs quiet cycles: the tensor-core operate wait and the burst-read drain.
- Never lets a burst-write payload be broken by a NOP, and issues a reset instruction automatically after hardware reset.

---
 rtl/instruction_stream_sequencer_pkg.sv | 36 +++
 rtl/instruction_stream_sequencer_if.sv | 28 ++
 rtl/instruction_stream_sequencer_fifo.sv | 55 +++++
 rtl/instruction_stream_sequencer.sv | 115 +++++++++++
 tb/tb_instruction_stream_sequencer.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_stream_sequencer_pkg.sv
// Shared opcodes, fixed instruction words and FSM states for the instruction stream sequencer.
// Pure declarations: no latency, no flow control.
package sequencer_pkg;

  localparam logic [1:0] OPC_GENERIC        = 2'b00;
  localparam logic [1:0] OPC_LOAD_IMMEDIATE = 2'b01;
  localparam logic [1:0] OPC_OPERATE        = 2'b10;
  localparam logic [1:0] OPC_BURST          = 2'b11;

  localparam logic [1:0] OPS_NOP   = 2'b00;
  localparam logic [1:0] OPS_RESET = 2'b11;

  localparam logic [15:0] NOP_INSTR   = {12'h000, OPS_NOP, OPC_GENERIC};
  localparam logic [15:0] RESET_INSTR = {12'h000, OPS_RESET, OPC_GENERIC};

  typedef enum logic [2:0] {
    INIT,
    ISSUE,
    OP_WAIT,
    BW_PAYLOAD,
    BR_DRAIN
  } sequencer_state_t;

  function automatic logic is_operate(input logic [15:0] instr);
    return instr[1:0] == OPC_OPERATE;
  endfunction

  function automatic logic is_burst_write(input logic [15:0] instr);
    return (instr[1:0] == OPC_BURST) && instr[2];
  endfunction

  function automatic logic is_burst_read(input logic [15:0] instr);
    return (instr[1:0] == OPC_BURST) && !instr[2];
  endfunction

endpackage

// File: rtl/instruction_stream_sequencer_if.sv
// Host-side valid/ready push bus plus the cpu-facing instruction and status outputs.
// master = host/loader side, slave = sequencer side.
interface instruction_stream_sequencer_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [15:0]   host_instruction_in;
  logic          host_valid_in;
  logic          host_ready_out;
  logic [15:0]   current_instruction_out;
  logic [CW-1:0] fifo_count_out;
  logic          busy_out;
  logic          burst_read_window_out;

  modport master (
    output host_instruction_in, host_valid_in,
    input  host_ready_out, current_instruction_out, fifo_count_out,
    input  busy_out, burst_read_window_out
  );

  modport slave (
    input  host_instruction_in, host_valid_in,
    output host_ready_out, current_instruction_out, fifo_count_out,
    output busy_out, burst_read_window_out
  );

endinterface

// File: rtl/instruction_stream_sequencer_fifo.sv
// Generic synchronous FIFO, head visible combinationally (show-ahead), count registered.
// Push is ignored when full and pop when empty; callers gate with o_full/o_empty.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [CW-1:0]    o_count,
  output logic             o_empty,
  output logic             o_full
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_stream_sequencer.sv
// Issues buffered host instructions to the cpu one per cycle (1-cycle FIFO-head-to-output latency),
// inserting NOPs for operate/burst-read waits; host is backpressured via host_ready_out when full or in INIT.
module instruction_stream_sequencer
  import sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH          = 8,
  parameter int OPERATE_WAIT_CYCLES = 7,
  parameter int BURST_WRITE_WORDS   = 5,
  parameter int BURST_READ_CYCLES   = 9
) (
  input logic clock_in,
  input logic reset_in,
  instruction_stream_sequencer_if.slave bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  sequencer_state_t r_state;
  logic [15:0]      r_instr;
  logic [7:0]       r_cnt;
  logic             r_busy;
  logic             r_br_window;

  logic [15:0]   w_head;
  logic [CW-1:0] w_count;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_bw_complete;

  assign bus.host_ready_out          = (r_state != INIT) && (w_count < CW'(FIFO_DEPTH));
  assign bus.current_instruction_out = r_instr;
  assign bus.fifo_count_out          = w_count;
  assign bus.busy_out                = r_busy;
  assign bus.burst_read_window_out   = r_br_window;

  assign w_push        = bus.host_valid_in && bus.host_ready_out;
  assign w_bw_complete = (w_count >= CW'(1 + BURST_WRITE_WORDS));

  // A burst-write header only leaves the FIFO once its whole payload is queued behind it.
  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      ISSUE:      w_pop = !w_empty && (!is_burst_write(w_head) || w_bw_complete);
      BW_PAYLOAD: w_pop = !w_empty;
      default:    w_pop = 1'b0;
    endcase
  end

  sync_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (clock_in),
    .i_rst      (reset_in),
    .i_push     (w_push),
    .i_push_dat (bus.host_instruction_in),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_count    (w_count),
    .o_empty    (w_empty),
    .o_full     (w_full)
  );

  // Status flags describe the state that produced the word currently on the output.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      r_state     <= INIT;
      r_instr     <= NOP_INSTR;
      r_cnt       <= '0;
      r_busy      <= 1'b1;
      r_br_window <= 1'b0;
    end else begin
      r_busy      <= (r_state != ISSUE);
      r_br_window <= (r_state == BR_DRAIN);
      case (r_state)
        INIT: begin
          r_instr <= RESET_INSTR;
          r_state <= ISSUE;
        end
        ISSUE: begin
          r_instr <= w_pop ? w_head : NOP_INSTR;
          if (w_pop) begin
            if (is_operate(w_head)) begin
              r_state <= OP_WAIT;
              r_cnt   <= 8'(OPERATE_WAIT_CYCLES);
            end else if (is_burst_write(w_head)) begin
              r_state <= BW_PAYLOAD;
              r_cnt   <= 8'(BURST_WRITE_WORDS);
            end else if (is_burst_read(w_head)) begin
              r_state <= BR_DRAIN;
              r_cnt   <= 8'(BURST_READ_CYCLES);
            end
          end
        end
        OP_WAIT, BR_DRAIN: begin
          r_instr <= NOP_INSTR;
          r_cnt   <= r_cnt - 8'd1;
          if (r_cnt == 8'd1) r_state <= ISSUE;
        end
        BW_PAYLOAD: begin
          r_instr <= w_pop ? w_head : NOP_INSTR;
          r_cnt   <= r_cnt - 8'd1;
          if (r_cnt == 8'd1) r_state <= ISSUE;
        end
        default: r_state <= INIT;
      endcase
    end
  end

  logic w_unused;
  assign w_unused = w_full;

endmodule

// File: tb/tb_instruction_stream_sequencer.sv
// Directed bench for instruction_stream_sequencer: per-feature tasks with hand-computed expectations.
module tb_instruction_stream_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  instruction_stream_sequencer_if #(.FIFO_DEPTH(8)) bus ();

  instruction_stream_sequencer #(
    .FIFO_DEPTH          (8),
    .OPERATE_WAIT_CYCLES (7),
    .BURST_WRITE_WORDS   (5),
    .BURST_READ_CYCLES   (9)
  ) dut (
    .clock_in (clk),
    .reset_in (rst),
    .bus      (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.host_valid_in = 1'b0;
    bus.host_instruction_in = 16'h0000;
    rst = 1'b1;
    tick();
    tick();
    vectors++;
    if (bus.current_instruction_out !== 16'h0000) begin miscompares++; $display("FAIL reset_instr got %h want 0000", bus.current_instruction_out); end
    vectors++;
    if (bus.fifo_count_out !== 4'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", bus.fifo_count_out); end
    vectors++;
    if (bus.host_ready_out !== 1'b0 || bus.busy_out !== 1'b1 || bus.burst_read_window_out !== 1'b0) begin
      miscompares++; $display("FAIL reset_flags got rdy=%b busy=%b brw=%b want 0 1 0", bus.host_ready_out, bus.busy_out, bus.burst_read_window_out);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (bus.current_instruction_out !== 16'h000C || bus.busy_out !== 1'b1) begin
      miscompares++; $display("FAIL init_word got %h busy=%b want 000C busy=1", bus.current_instruction_out, bus.busy_out);
    end
    vectors++;
    if (bus.host_ready_out !== 1'b1) begin miscompares++; $display("FAIL init_ready got %b want 1", bus.host_ready_out); end
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (bus.current_instruction_out !== 16'h0000 || bus.busy_out !== 1'b0) begin
        miscompares++; $display("FAIL idle_nop[%0d] got %h busy=%b want 0000 busy=0", i, bus.current_instruction_out, bus.busy_out);
      end
    end
  endtask

  task automatic test_operate();
    logic [15:0] exp_out [3];
    exp_out[0] = 16'h0000; exp_out[1] = 16'h1A09; exp_out[2] = 16'h0002;
    bus.host_valid_in = 1'b1;
    bus.host_instruction_in = 16'h1A09;
    tick();
    vectors++;
    if (bus.current_instruction_out !== exp_out[0]) begin miscompares++; $display("FAIL op_seq0 got %h want %h", bus.current_instruction_out, exp_out[0]); end
    bus.host_instruction_in = 16'h0002;
    tick();
    vectors++;
    if (bus.current_instruction_out !== exp_out[1]) begin miscompares++; $display("FAIL op_seq1 got %h want %h", bus.current_instruction_out, exp_out[1]); end
    bus.host_instruction_in = 16'h0001;
    tick();
    bus.host_valid_in = 1'b0;
    vectors++;
    if (bus.current_instruction_out !== exp_out[2] || bus.busy_out !== 1'b0) begin
      miscompares++; $display("FAIL op_issue got %h busy=%b want 0002 busy=0", bus.current_instruction_out, bus.busy_out);
    end
    for (int i = 0; i < 7; i++) begin
      tick();
      vectors++;
      if (bus.current_instruction_out !== 16'h0000 || bus.busy_out !== 1'b1) begin
        miscompares++; $display("FAIL op_wait[%0d] got %h busy=%b want 0000 busy=1", i, bus.current_instruction_out, bus.busy_out);
      end
    end
    tick();
    vectors++;
    if (bus.current_instruction_out !== 16'h0001 || bus.busy_out !== 1'b0) begin
      miscompares++; $display("FAIL op_after got %h busy=%b want 0001 busy=0", bus.current_instruction_out, bus.busy_out);
    end
    tick();
    vectors++;
    if (bus.current_instruction_out !== 16'h0000) begin miscompares++; $display("FAIL op_drain got %h want 0000", bus.current_instruction_out); end
  endtask

  task automatic test_burst_write();
    logic [15:0] seq [6];
    seq[0] = 16'h0007; seq[1] = 16'hAA11; seq[2] = 16'hBB22;
    seq[3] = 16'hCC33; seq[4] = 16'hDD44; seq[5] = 16'hEE55;
    bus.host_valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.host_instruction_in = seq[i];
      tick();
      vectors++;
      if (bus.current_instruction_out !== 16'h0000) begin miscompares++; $display("FAIL bw_hold_push[%0d] got %h want 0000", i, bus.current_instruction_out); end
    end
    bus.host_valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (bus.current_instruction_out !== 16'h0000 || bus.fifo_count_out !== 4'd4) begin
        miscompares++; $display("FAIL bw_hold[%0d] got %h cnt=%0d want 0000 cnt=4", i, bus.current_instruction_out, bus.fifo_count_out);
      end
    end
    bus.host_valid_in = 1'b1;
    for (int i = 4; i < 6; i++) begin
      bus.host_instruction_in = seq[i];
      tick();
      vectors++;
      if (bus.current_instruction_out !== 16'h0000) begin miscompares++; $display("FAIL bw_fill[%0d] got %h want 0000", i, bus.current_instruction_out); end
    end
    bus.host_valid_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++;
      if (bus.current_instruction_out !== seq[i]) begin miscompares++; $display("FAIL bw_burst[%0d] got %h want %h", i, bus.current_instruction_out, seq[i]); end
    end
    tick();
    vectors++;
    if (bus.current_instruction_out !== 16'h0000 || bus.fifo_count_out !== 4'd0) begin
      miscompares++; $display("FAIL bw_end got %h cnt=%0d want 0000 cnt=0", bus.current_instruction_out, bus.fifo_count_out);
    end
  endtask

  task automatic test_burst_read();
    bus.host_valid_in = 1'b1;
    bus.host_instruction_in = 16'h0003;
    tick();
    bus.host_valid_in = 1'b0;
    tick();
    vectors++;
    if (bus.current_instruction_out !== 16'h0003 || bus.burst_read_window_out !== 1'b0) begin
      miscompares++; $display("FAIL br_issue got %h brw=%b want 0003 brw=0", bus.current_instruction_out, bus.burst_read_window_out);
    end
    for (int i = 0; i < 9; i++) begin
      tick();
      vectors++;
      if (bus.current_instruction_out !== 16'h0000 || bus.burst_read_window_out !== 1'b1) begin
        miscompares++; $display("FAIL br_window[%0d] got %h brw=%b want 0000 brw=1", i, bus.current_instruction_out, bus.burst_read_window_out);
      end
    end
    tick();
    vectors++;
    if (bus.burst_read_window_out !== 1'b0 || bus.busy_out !== 1'b0) begin
      miscompares++; $display("FAIL br_close got brw=%b busy=%b want 0 0", bus.burst_read_window_out, bus.busy_out);
    end
  endtask

  task automatic test_back_to_back_full();
    logic [15:0] w [9];
    for (int i = 0; i < 9; i++) w[i] = 16'h1001 + 16'(i << 4);
    bus.host_valid_in = 1'b1;
    bus.host_instruction_in = 16'h0002;
    tick();
    for (int i = 0; i < 8; i++) begin
      bus.host_instruction_in = w[i];
      tick();
      vectors++;
      if (bus.fifo_count_out !== 4'(i + 1) || bus.host_ready_out !== (i < 7)) begin
        miscompares++; $display("FAIL full_fill[%0d] got cnt=%0d rdy=%b want cnt=%0d rdy=%b", i, bus.fifo_count_out, bus.host_ready_out, i + 1, (i < 7));
      end
      vectors++;
      if (bus.current_instruction_out !== ((i == 0) ? 16'h0002 : 16'h0000)) begin
        miscompares++; $display("FAIL full_out[%0d] got %h", i, bus.current_instruction_out);
      end
    end
    bus.host_instruction_in = w[8];
    tick();
    vectors++;
    if (bus.current_instruction_out !== w[0] || bus.fifo_count_out !== 4'd7) begin
      miscompares++; $display("FAIL full_pop0 got %h cnt=%0d want %h cnt=7", bus.current_instruction_out, bus.fifo_count_out, w[0]);
    end
    tick();
    bus.host_valid_in = 1'b0;
    vectors++;
    if (bus.current_instruction_out !== w[1] || bus.fifo_count_out !== 4'd7) begin
      miscompares++; $display("FAIL full_pop1 got %h cnt=%0d want %h cnt=7", bus.current_instruction_out, bus.fifo_count_out, w[1]);
    end
    for (int i = 2; i < 9; i++) begin
      tick();
      vectors++;
      if (bus.current_instruction_out !== w[i]) begin miscompares++; $display("FAIL full_order[%0d] got %h want %h", i, bus.current_instruction_out, w[i]); end
    end
    tick();
    vectors++;
    if (bus.current_instruction_out !== 16'h0000 || bus.fifo_count_out !== 4'd0) begin
      miscompares++; $display("FAIL full_empty got %h cnt=%0d want 0000 cnt=0", bus.current_instruction_out, bus.fifo_count_out);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [15:0] seq [6];
    seq[0] = 16'h0007; seq[1] = 16'h5101; seq[2] = 16'h5202;
    seq[3] = 16'h5303; seq[4] = 16'h5404; seq[5] = 16'h5505;
    bus.host_valid_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.host_instruction_in = seq[i];
      tick();
    end
    bus.host_valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (bus.current_instruction_out !== seq[i]) begin miscompares++; $display("FAIL mid_pre[%0d] got %h want %h", i, bus.current_instruction_out, seq[i]); end
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.current_instruction_out !== 16'h0000 || bus.fifo_count_out !== 4'd0) begin
      miscompares++; $display("FAIL mid_abort got %h cnt=%0d want 0000 cnt=0", bus.current_instruction_out, bus.fifo_count_out);
    end
    vectors++;
    if (bus.busy_out !== 1'b1 || bus.host_ready_out !== 1'b0) begin
      miscompares++; $display("FAIL mid_abort_flags got busy=%b rdy=%b want 1 0", bus.busy_out, bus.host_ready_out);
    end
    tick();
    rst = 1'b0;
    tick();
    vectors++;
    if (bus.current_instruction_out !== 16'h000C) begin miscompares++; $display("FAIL mid_init got %h want 000C", bus.current_instruction_out); end
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (bus.current_instruction_out !== 16'h0000 || bus.fifo_count_out !== 4'd0) begin
        miscompares++; $display("FAIL mid_after[%0d] got %h cnt=%0d want 0000 cnt=0", i, bus.current_instruction_out, bus.fifo_count_out);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_operate();
    test_burst_write();
    test_burst_read();
    test_back_to_back_full();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
